// File: rtl/mips_cpu_mem_ctrl.sv
// mips_cpu_mem_ctrl: arbitrates instruction-cache and data-cache misses onto a
// single Avalon-MM master port. Performs one word transfer per request: a read
// refill (strobed back to the requesting cache) or a data write (strobed to the
// data cache on acceptance).
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   i_addr, i_stall             instruction-cache miss address / request
//   i_data, i_data_valid        refill word and strobe to the instruction cache
//   d_addr, d_read, d_write     data-cache address / read-miss / write request
//   d_byteenable, d_writedata   write lanes and word
//   d_data, d_data_valid        refill word, read-refill or write-done strobe
//   address, read, write,       Avalon master outputs
//   byteenable, writedata
//   waitrequest, readdata       Avalon slave stall and read data (one cycle
//                               after the read is accepted)
module mips_cpu_mem_ctrl #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_stall,
  output logic [31:0] i_data,
  output logic        i_data_valid,
  input  logic [31:0] d_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byteenable,
  input  logic [31:0] d_writedata,
  output logic [31:0] d_data,
  output logic        d_data_valid,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [2:0] {
    StIdle,
    StIReq,
    StIResp,
    StDRReq,
    StDRResp,
    StDWReq
  } state_t;

  state_t      state_q, state_d;
  logic        pend_i_q, pend_i_d;  // instruction side lost arbitration
  logic        pend_d_q, pend_d_d;  // data side lost arbitration
  logic [31:0] address_q;
  logic [3:0]  byteenable_q;
  logic [31:0] writedata_q;

  logic   d_req;
  state_t d_kind;
  logic   pend_go;
  state_t pend_state;
  logic   enter_req;

  // A simultaneous read and write from the data cache is a write.
  assign d_req      = d_read | d_write;
  assign d_kind     = d_write ? StDWReq : StDRReq;
  assign pend_go    = pend_i_q | pend_d_q;
  assign pend_state = pend_i_q ? StIReq : d_kind;
  assign enter_req  = (state_d != state_q) &&
                      ((state_d == StIReq) || (state_d == StDRReq) || (state_d == StDWReq));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      pend_i_q <= 1'b0;
      pend_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_i_q <= pend_i_d;
      pend_d_q <= pend_d_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    pend_i_d = pend_i_q;
    pend_d_d = pend_d_q;
    unique case (state_q)
      StIdle: begin
        if (pend_go) begin
          // Only reached when a write won; reads hand over straight from RESP.
          state_d  = pend_state;
          pend_i_d = 1'b0;
          pend_d_d = 1'b0;
        end else if (i_stall && d_req) begin
          if (DATA_FIRST) begin
            state_d  = d_kind;
            pend_i_d = 1'b1;
          end else begin
            state_d  = StIReq;
            pend_d_d = 1'b1;
          end
        end else if (d_req) begin
          state_d = d_kind;
        end else if (i_stall) begin
          state_d = StIReq;
        end
      end
      StIReq:  if (!waitrequest) state_d = StIResp;
      StDRReq: if (!waitrequest) state_d = StDRResp;
      StDWReq: if (!waitrequest) state_d = StIdle;
      StIResp, StDRResp: begin
        if (pend_go) begin
          state_d  = pend_state;
          pend_i_d = 1'b0;
          pend_d_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Transaction fields are captured on entry to a request state and held
  // until the next one begins, so they cannot move while waitrequest stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      address_q    <= 32'h0;
      byteenable_q <= 4'h0;
      writedata_q  <= 32'h0;
    end else if (enter_req) begin
      writedata_q <= d_writedata;
      if (state_d == StIReq) begin
        address_q    <= i_addr & 32'hFFFF_FFFC;
        byteenable_q <= 4'hF;
      end else if (state_d == StDRReq) begin
        address_q    <= d_addr & 32'hFFFF_FFFC;
        byteenable_q <= 4'hF;
      end else begin
        address_q    <= d_addr & 32'hFFFF_FFFC;
        byteenable_q <= d_byteenable;
      end
    end
  end

  // Outputs
  always_comb begin
    read         = (state_q == StIReq) || (state_q == StDRReq);
    write        = (state_q == StDWReq);
    i_data_valid = (state_q == StIResp);
    // Write-done fires in the acceptance cycle itself.
    d_data_valid = (state_q == StDRResp) || ((state_q == StDWReq) && !waitrequest);
    i_data       = (state_q == StIResp) ? readdata : 32'h0;
    d_data       = (state_q == StDRResp) ? readdata : 32'h0;
    address      = address_q;
    byteenable   = byteenable_q;
    writedata    = writedata_q;
  end

endmodule
